sseg_frame_arbiter: RTL and testbench
=====================================

# sseg_frame_arbiter

Arbitrates the shared 4-digit seven-segment display between two frame requesters, e.g. the square-wave parameter readout and a status/message source. The arbiter owns the hex/dp inputs that feed the per-digit `hex_to_sseg` decoders ahead of `led_4_1_mux`. It grants the display to one requester at a time with a guaranteed minimum hold time, round-robin on contention, and blanks the display when idle.

## Interface
Parameters:
- `HOLD_CYCLES`, default 100_000_000: minimum grant duration in `i_clk` cycles (1 s at 100 MHz); must be ≥ 2.
- `CW`, default `$clog2(HOLD_CYCLES)`: hold counter width; not overridden.

Ports:
- `i_clk`  in  1  system clock; all logic on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_req`  in  2  display request, bit n = requester n; level-sensitive.
- `i_frame0` / `i_frame1`  in  16  four hex nibbles, [3:0] = rightmost digit.
- `i_dp0` / `i_dp1`  in  4  decimal-point enables, bit n = digit n.
- `o_gnt`  out  2  one-hot grant; 2'b00 when idle.
- `o_hex`  out  16  frame presented to the decoders.
- `o_dp`  out  4  decimal points presented to the decoders.
- `o_blank`  out  1  1 = no owner; downstream forces all segments off.
- `o_frame_stb`  out  1  one-cycle pulse on every change of owner, including to idle.

## Operation
- States: IDLE, OWN0, OWN1. `last` (1 bit) records the most recent owner; reset value 1, so requester 0 wins first contention.
- IDLE: if exactly one `i_req` bit is set, go to that OWN state. If both are set, grant `~last`.
- Entering OWNn:
  - load hold counter to 0;
  - set `last`=n;
  - `o_gnt`=one-hot n, `o_blank`=0, pulse `o_frame_stb`.
- In OWNn while `i_req[n]`=1: `o_hex`/`o_dp` track `i_frameN`/`i_dpN` every cycle (registered).
- In OWNn while `i_req[n]`=0: `o_hex`/`o_dp` freeze at their last value; the grant is kept until the hold expires.
- Hold counter increments each cycle in OWN and saturates at `HOLD_CYCLES-1` (expired).
- When expired, evaluate every cycle:
  - other requester set: switch owner.
  - else owner still requesting: stay in OWN; counter stays saturated.
  - else: go to IDLE with `o_gnt`=0, `o_blank`=1, pulse `o_frame_stb`; `o_hex`/`o_dp` hold their last values.
- A switch OWN0↔OWN1 passes through no IDLE cycle. The new owner's frame appears on the same edge as the new grant.
- Counter arithmetic is unsigned CW-bit and never wraps.

## Timing
- All outputs are registered.
- Reset values: `o_gnt`=0, `o_hex`=16'h0000, `o_dp`=0, `o_blank`=1, `o_frame_stb`=0, state IDLE, counter 0, `last`=1.
- Request to grant: 1 cycle. `i_req` is sampled at edge k; `o_gnt`, `o_hex` and `o_frame_stb` are valid after edge k.
- Frame tracking latency: 1 cycle.
- Minimum ownership is `HOLD_CYCLES` cycles: grant asserted at edge k, earliest change at edge k+`HOLD_CYCLES`.
- Simultaneous events:
  - release and new request in the same cycle at expiry: switch directly, no IDLE.
  - both requests arriving in the same cycle: round-robin.
- Reset mid-ownership: next edge returns all reset values; no strobe is generated by reset.

## Configuration
- `SSEG_ARB_PREEMPT_EN` defined: requester 0 is high priority. In OWN1, `i_req[0]`=1 switches to OWN0 on the next edge regardless of the hold counter. Requester 1 still waits for expiry, and round-robin applies only from IDLE.
- `SSEG_ARB_PREEMPT_EN` undefined: strict minimum hold for both requesters; no preemption logic is synthesized.

## Test plan
(`HOLD_CYCLES`=8)
- Reset check: assert `i_rst` for 2 cycles, then release with `i_req`=0. Required: `o_gnt`=0, `o_blank`=1, `o_hex`=0000, no strobe.
- Single request: `i_req`=01, `i_frame0`=16'h1234, `i_dp0`=4'b0100. Required one cycle later: `o_gnt`=01, `o_hex`=1234, `o_dp`=0100, one strobe pulse. Changing frame0 to 16'hABCD shows ABCD one cycle later.
- Early release: `i_req[0]` held for 3 cycles only. Required: `o_gnt`=01 for exactly 8 cycles with `o_hex` frozen, then IDLE with `o_blank`=1 and a strobe.
- Contention from reset: `i_req`=11 applied together. Required: OWN0 for 8 cycles, then OWN1 with no idle gap and `o_hex`=`i_frame1`; while both stay requesting, ownership alternates every 8 cycles.
- Late requester: OWN1 active, `i_req[0]` asserted at hold cycle 2.
  - Without `SSEG_ARB_PREEMPT_EN`: switch at cycle 8.
  - With it: `o_gnt`=01 one cycle later.
- Reset mid-grant: pulse `i_rst` during OWN0 at hold cycle 5. Required: all reset values next cycle. Afterwards, `i_req`=11 grants requester 0 (`last` reset to 1).

Source files
------------

// File: rtl/sseg_frame_arbiter.sv
// Two-requester arbiter for the shared 4-digit seven-segment display: minimum hold, round-robin, blank when idle.
// Optional macro SSEG_ARB_PREEMPT_EN lets requester 0 preempt requester 1 regardless of the hold counter.
module sseg_frame_arbiter #(
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int CW          = $clog2(HOLD_CYCLES)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_req,
  input  logic [15:0] i_frame0,
  input  logic [15:0] i_frame1,
  input  logic [3:0]  i_dp0,
  input  logic [3:0]  i_dp1,
  output logic [1:0]  o_gnt,
  output logic [15:0] o_hex,
  output logic [3:0]  o_dp,
  output logic        o_blank,
  output logic        o_frame_stb
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [15:0]   hex_q, hex_d;
  logic [3:0]    dp_q, dp_d;
  logic          blank_q, blank_d;
  logic          stb_q, stb_d;

  logic own;
  logic own_req;
  logic oth_req;
  logic expired;
  logic take;
  logic take_n;
  logic track;
  logic release_own;

  assign own     = (state_q == OWN1);
  assign own_req = own ? i_req[1] : i_req[0];
  assign oth_req = own ? i_req[0] : i_req[1];
  assign expired = (cnt_q == CNT_MAX);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    hex_d       = hex_q;
    dp_d        = dp_q;
    blank_d     = blank_q;
    stb_d       = 1'b0;
    take        = 1'b0;
    take_n      = 1'b0;
    track       = 1'b0;
    release_own = 1'b0;

    // Decide what happens this cycle; the register updates are applied below.
    case (state_q)
      IDLE: begin
        if (i_req != 2'b00) begin
          take   = 1'b1;
          take_n = (i_req == 2'b11) ? ~last_q : i_req[1];
        end
      end
      OWN0, OWN1: begin
        if (!expired) cnt_d = cnt_q + CW'(1);
        if (expired && oth_req) begin
          take   = 1'b1;
          take_n = ~own;
        end else if (own_req) begin
          track = 1'b1;
        end else if (expired) begin
          release_own = 1'b1;
        end
`ifdef SSEG_ARB_PREEMPT_EN
        if (own && i_req[0]) begin
          take   = 1'b1;
          take_n = 1'b0;
          track  = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d = take_n ? OWN1 : OWN0;
      cnt_d   = '0;
      last_d  = take_n;
      gnt_d   = take_n ? 2'b10 : 2'b01;
      blank_d = 1'b0;
      stb_d   = 1'b1;
      hex_d   = take_n ? i_frame1 : i_frame0;
      dp_d    = take_n ? i_dp1 : i_dp0;
    end else if (track) begin
      hex_d = own ? i_frame1 : i_frame0;
      dp_d  = own ? i_dp1 : i_dp0;
    end else if (release_own) begin
      // Frame and decimal points keep their last values; blank hides them.
      state_d = IDLE;
      cnt_d   = '0;
      gnt_d   = 2'b00;
      blank_d = 1'b1;
      stb_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
      hex_q   <= 16'h0000;
      dp_q    <= 4'h0;
      blank_q <= 1'b1;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      hex_q   <= hex_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      stb_q   <= stb_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_hex       = hex_q;
  assign o_dp        = dp_q;
  assign o_blank     = blank_q;
  assign o_frame_stb = stb_q;

endmodule

// File: tb/tb_sseg_frame_arbiter.sv
// Randomized and directed bench for sseg_frame_arbiter against an ownership/time reference model.
module tb_sseg_frame_arbiter;

  localparam int HOLD = 8;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [1:0]  i_req = 2'b00;
  logic [15:0] i_frame0 = 16'h0;
  logic [15:0] i_frame1 = 16'h0;
  logic [3:0]  i_dp0 = 4'h0;
  logic [3:0]  i_dp1 = 4'h0;
  logic [1:0]  o_gnt;
  logic [15:0] o_hex;
  logic [3:0]  o_dp;
  logic        o_blank;
  logic        o_frame_stb;

  int n_checks = 0;
  int n_err = 0;

  // Reference model: who owns the display and the edge at which they got it.
  int          m_owner = -1;
  int          m_last = 1;
  int          m_t = 0;
  int          m_gedge = 0;
  logic [15:0] m_hex = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  logic        m_stb = 1'b0;

  sseg_frame_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req),
    .i_frame0(i_frame0), .i_frame1(i_frame1), .i_dp0(i_dp0), .i_dp1(i_dp1),
    .o_gnt(o_gnt), .o_hex(o_hex), .o_dp(o_dp), .o_blank(o_blank), .o_frame_stb(o_frame_stb)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] frame_of(input int n);
    return (n == 1) ? i_frame1 : i_frame0;
  endfunction

  function automatic logic [3:0] dp_of(input int n);
    return (n == 1) ? i_dp1 : i_dp0;
  endfunction

  task automatic model_grant(input int n);
    m_owner = n;
    m_last  = n;
    m_gedge = m_t;
    m_hex   = frame_of(n);
    m_dp    = dp_of(n);
    m_stb   = 1'b1;
  endtask

  task automatic model_edge();
    int  n;
    int  age;
    bit  preempt;
    m_t++;
    m_stb = 1'b0;
    if (i_rst) begin
      m_owner = -1;
      m_last  = 1;
      m_hex   = 16'h0;
      m_dp    = 4'h0;
    end else if (m_owner < 0) begin
      if (i_req == 2'b11) model_grant(1 - m_last);
      else if (i_req == 2'b01) model_grant(0);
      else if (i_req == 2'b10) model_grant(1);
    end else begin
      n = m_owner;
      age = m_t - m_gedge;
      preempt = 1'b0;
`ifdef SSEG_ARB_PREEMPT_EN
      preempt = (n == 1) && i_req[0];
`endif
      if (preempt) model_grant(0);
      else if (age >= HOLD && i_req[1-n]) model_grant(1 - n);
      else if (i_req[n]) begin
        m_hex = frame_of(n);
        m_dp  = dp_of(n);
      end else if (age >= HOLD) begin
        m_owner = -1;
        m_stb   = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    logic [1:0] eg;
    eg = (m_owner < 0) ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
    check("gnt", 32'(o_gnt), 32'(eg));
    check("blank", 32'(o_blank), 32'(m_owner < 0));
    check("stb", 32'(o_frame_stb), 32'(m_stb));
    check("hex", 32'(o_hex), 32'(m_hex));
    check("dp", 32'(o_dp), 32'(m_dp));
  endtask

  task automatic step();
    @(posedge i_clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int cycles);
    i_rst = 1'b1;
    i_req = 2'b00;
    repeat (cycles) step();
    i_rst = 1'b0;
  endtask

  initial begin
    int cnt;
    int wait_n;
    int exp_wait;

    // Reset
    do_reset(2);
    step();
    check("rst_gnt", 32'(o_gnt), 32'h0);
    check("rst_blank", 32'(o_blank), 32'h1);
    check("rst_hex", 32'(o_hex), 32'h0);
    check("rst_stb", 32'(o_frame_stb), 32'h0);

    // Single request and frame tracking
    i_frame0 = 16'h1234;
    i_dp0 = 4'b0100;
    i_req = 2'b01;
    step();
    check("single_gnt", 32'(o_gnt), 32'h1);
    check("single_hex", 32'(o_hex), 32'h1234);
    check("single_dp", 32'(o_dp), 32'h4);
    check("single_stb", 32'(o_frame_stb), 32'h1);
    i_frame0 = 16'hABCD;
    step();
    check("track_hex", 32'(o_hex), 32'hABCD);
    check("track_stb", 32'(o_frame_stb), 32'h0);
    i_req = 2'b00;
    repeat (12) step();

    // Early release: grant lasts exactly HOLD cycles
    cnt = 0;
    i_req = 2'b01;
    i_frame0 = 16'h5A5A;
    repeat (3) begin
      step();
      if (o_gnt == 2'b01) cnt++;
    end
    i_req = 2'b00;
    i_frame0 = 16'hFFFF;
    repeat (12) begin
      step();
      if (o_gnt == 2'b01) cnt++;
    end
    check("early_release_len", 32'(cnt), 32'(HOLD));
    check("early_release_hex", 32'(o_hex), 32'h5A5A);

    // Contention from reset
    do_reset(2);
    i_req = 2'b11;
    i_frame1 = 16'h7777;
    step();
    check("cont_first", 32'(o_gnt), 32'h1);
    repeat (40) begin
      i_frame0 = 16'($urandom);
      i_frame1 = 16'($urandom);
      step();
    end

    // Late requester while requester 1 owns
    do_reset(2);
    i_req = 2'b10;
    step();
    step();
    i_req = 2'b11;
    wait_n = 0;
    while (o_gnt != 2'b01 && wait_n < 4 * HOLD) begin
      step();
      wait_n++;
    end
`ifdef SSEG_ARB_PREEMPT_EN
    exp_wait = 1;
`else
    exp_wait = HOLD - 1;
`endif
    check("late_req_wait", 32'(wait_n), 32'(exp_wait));
    repeat (10) step();

    // Reset mid-grant
    do_reset(2);
    i_req = 2'b01;
    repeat (6) step();
    i_rst = 1'b1;
    step();
    check("midrst_gnt", 32'(o_gnt), 32'h0);
    check("midrst_blank", 32'(o_blank), 32'h1);
    check("midrst_stb", 32'(o_frame_stb), 32'h0);
    check("midrst_hex", 32'(o_hex), 32'h0);
    i_rst = 1'b0;
    i_req = 2'b11;
    step();
    check("midrst_rr", 32'(o_gnt), 32'h1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) i_req = 2'($urandom);
      if ($urandom_range(0, 3) == 0) i_frame0 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) i_frame1 = 16'($urandom);
      if ($urandom_range(0, 7) == 0) i_dp0 = 4'($urandom);
      if ($urandom_range(0, 7) == 0) i_dp1 = 4'($urandom);
      i_rst = ($urandom_range(0, 499) == 0);
      step();
    end
    i_rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
